// File: rtl/img_pkg.sv
// Shared image-pipeline constants: frame geometry, pixel widths, luma weights and
// the frame-walker FSM encoding.
package img_pkg;

    localparam int unsigned IMG_WIDTH   = 220;
    localparam int unsigned IMG_HEIGHT  = 220;
    localparam int unsigned PIXEL_COUNT = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned ADDR_BITS   = 16;

    localparam int unsigned RGB_WIDTH  = 24;
    localparam int unsigned GRAY_WIDTH = 8;

    // Weights sum to 256, so the 16-bit weighted sum never overflows.
    localparam int unsigned W_R = 77;
    localparam int unsigned W_G = 150;
    localparam int unsigned W_B = 29;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/rgb_gray_luma.sv
// Combinational 24-bit RGB to 8-bit luma: Y = (77*R + 150*G + 29*B) >> 8, truncated.
module rgb_gray_luma
    import img_pkg::*;
(
    input  logic [RGB_WIDTH-1:0]  rgb_i,
    output logic [GRAY_WIDTH-1:0] gray_o
);

    logic [15:0] sum;

    always_comb begin
        sum = 16'(W_R) * {8'd0, rgb_i[23:16]}
            + 16'(W_G) * {8'd0, rgb_i[15:8]}
            + 16'(W_B) * {8'd0, rgb_i[7:0]};
        gray_o = sum[15:8];
    end

endmodule

// File: rtl/rgb_to_gray_converter.sv
// Walks one RGB frame out of the source BRAM, converts each pixel to luma and writes it at the
// same address into the grey BRAM; pulses done once the last grey pixel is written.
module rgb_to_gray_converter #(
    parameter int unsigned PIXEL_COUNT = img_pkg::PIXEL_COUNT,
    parameter int unsigned ADDR_BITS   = img_pkg::ADDR_BITS
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            src_en,
    output logic [ADDR_BITS-1:0]            src_addr,
    input  logic [img_pkg::RGB_WIDTH-1:0]   src_rdata,
    output logic                            dst_en,
    output logic                            dst_we,
    output logic [ADDR_BITS-1:0]            dst_addr,
    output logic [img_pkg::GRAY_WIDTH-1:0]  dst_wdata
);

    import img_pkg::*;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIXEL_COUNT - 1);

    state_e                  state_q, state_d;
    logic                    drain_q, drain_d;
    logic                    src_en_q, src_en_d;
    logic [ADDR_BITS-1:0]    src_addr_q, src_addr_d;
    logic                    vld1_q, vld1_d;
    logic [ADDR_BITS-1:0]    addr1_q, addr1_d;
    logic                    dst_en_q, dst_en_d;
    logic [ADDR_BITS-1:0]    dst_addr_q, dst_addr_d;
    logic [GRAY_WIDTH-1:0]   dst_wdata_q, dst_wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [GRAY_WIDTH-1:0]   luma;

    rgb_gray_luma u_luma (
        .rgb_i  (src_rdata),
        .gray_o (luma)
    );

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        src_en_d   = 1'b0;
        src_addr_d = src_addr_q;

        // Stage 1 tracks the read whose data lands this cycle; stage 2 is the write.
        vld1_d      = src_en_q;
        addr1_d     = src_addr_q;
        dst_en_d    = vld1_q;
        dst_addr_d  = addr1_q;
        dst_wdata_d = vld1_q ? luma : dst_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    src_en_d   = 1'b1;
                    src_addr_d = '0;
                end
            end
            RUN: begin
                if (src_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    src_en_d   = 1'b1;
                    src_addr_d = src_addr_q + ADDR_BITS'(1);
                end
            end
            DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            drain_q     <= 1'b0;
            src_en_q    <= 1'b0;
            src_addr_q  <= '0;
            vld1_q      <= 1'b0;
            addr1_q     <= '0;
            dst_en_q    <= 1'b0;
            dst_addr_q  <= '0;
            dst_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            src_en_q    <= src_en_d;
            src_addr_q  <= src_addr_d;
            vld1_q      <= vld1_d;
            addr1_q     <= addr1_d;
            dst_en_q    <= dst_en_d;
            dst_addr_q  <= dst_addr_d;
            dst_wdata_q <= dst_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign src_en    = src_en_q;
    assign src_addr  = src_addr_q;
    assign dst_en    = dst_en_q;
    assign dst_we    = dst_en_q;
    assign dst_addr  = dst_addr_q;
    assign dst_wdata = dst_wdata_q;

endmodule
